// File: rtl/blur_pkg.sv
// Shared widths and the shift-and-saturate helper for the blur result packer.
package blur_pkg;

  localparam int RESULT_W    = 32;
  localparam int PIX_W       = 8;
  localparam int PACK_W      = 32;
  localparam int FRAME_CNT_W = 16;

  // Logical right shift, then clamp anything above 8 bits to full white.
  function automatic logic [PIX_W-1:0] sat_shift(
    input logic [RESULT_W-1:0] data,
    input int unsigned         shift
  );
    logic [RESULT_W-1:0] shifted;
    shifted = data >> shift;
    if (shifted > RESULT_W'(255)) begin
      return '1;
    end
    return shifted[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/blur_pix_sat.sv
// Combinational normalisation of one 32-bit blur result to an 8-bit pixel.
module blur_pix_sat
  import blur_pkg::*;
#(
  parameter int unsigned SHIFT = 4
) (
  input  logic [RESULT_W-1:0] data,
  output logic [PIX_W-1:0]    pix
);

  // Shift by the kernel normalisation and saturate to 0xFF.
  always_comb begin
    pix = sat_shift(data, SHIFT);
  end

endmodule

// File: rtl/blur_result_packer.sv
// Packs four normalised blur pixels per 32-bit word, tagging line and frame ends.
module blur_result_packer
  import blur_pkg::*;
#(
  parameter int unsigned SHIFT = 4,
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_result_vld,
  input  logic [RESULT_W-1:0]    i_result_data,
  output logic                   i_result_busy,
  output logic                   o_pack_vld,
  output logic [PACK_W-1:0]      o_pack_data,
  output logic                   o_pack_eol,
  output logic                   o_pack_last,
  input  logic                   o_pack_busy,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [PIX_W-1:0]   pix;
  logic [3*PIX_W-1:0] acc;
  logic [1:0]         byte_cnt;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               in_xfer;
  logic               out_xfer;
  logic               word_done;
  logic               at_eol;
  logic               at_last;

  blur_pix_sat #(.SHIFT(SHIFT)) u_pix_sat (
    .data (i_result_data),
    .pix  (pix)
  );

  // Busy depends on registered state only, so a drain costs one bubble
  // cycle instead of a combinational path from o_pack_busy.
  assign i_result_busy = (byte_cnt == 2'd3) && o_pack_vld;
  assign in_xfer       = i_result_vld && !i_result_busy;
  assign out_xfer      = o_pack_vld && !o_pack_busy;
  assign word_done     = in_xfer && (byte_cnt == 2'd3);
  assign at_eol        = (col == COL_LAST);
  assign at_last       = at_eol && (row == ROW_LAST);

  // Collect the first three pixels of a word; the fourth goes straight out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc      <= '0;
      byte_cnt <= '0;
    end else if (in_xfer) begin
      if (byte_cnt != 2'd3) begin
        acc[byte_cnt*PIX_W +: PIX_W] <= pix;
      end
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Track pixel position within the frame and count completed frames.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col         <= '0;
      row         <= '0;
      o_frame_cnt <= '0;
    end else if (in_xfer) begin
      if (at_eol) begin
        col <= '0;
        if (at_last) begin
          row         <= '0;
          o_frame_cnt <= o_frame_cnt + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Output word register; a word can only complete while the register is
  // free (busy blocks the fourth pixel otherwise), so load has priority.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pack_vld  <= 1'b0;
      o_pack_data <= '0;
      o_pack_eol  <= 1'b0;
      o_pack_last <= 1'b0;
    end else if (word_done) begin
      o_pack_vld  <= 1'b1;
      o_pack_data <= {pix, acc};
      o_pack_eol  <= at_eol;
      o_pack_last <= at_last;
    end else if (out_xfer) begin
      o_pack_vld <= 1'b0;
    end
  end

endmodule
